icache_refill_ctrl: RTL and testbench

Instruction-cache miss handler. It accepts a miss, selects a victim way, issues a line request to L2 and waits for the response. It then writes the returned line, tag and way into the cache arrays. It consumes the pseudo-random replacement way from the icache replacement generator, and pulses that generator's advance enable whenever it uses the random way.

---
 rtl/icache_refill_ctrl.sv | 175 +++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Instruction-cache miss handler. Accepts one miss at a time, picks a victim
// way, requests the line from L2, waits for the single-beat response and
// writes line/tag/way into the cache arrays.
//
// State table:
//   state   | meaning
//   S_IDLE  | ready for a miss; victim chosen and address latched on acceptance
//   S_REQ   | l2 request valid, held until handshake or flush
//   S_WAIT  | request accepted, waiting for response; flush arms kill
//   S_WRITE | one-cycle array write of the returned line
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   miss_i, miss_paddr_i          miss request and physical address
//   valid_bits_i                  valid bits of the indexed set
//   lfsr_way_i, lfsr_en_o         random way in, advance pulse out
//   l2_req_*                      line request to L2 (valid/ready, address)
//   l2_resp_*                     single-beat L2 response (no backpressure)
//   flush_i                       kill the in-flight refill
//   wr_en_o, wr_way_o, wr_idx_o,
//   wr_tag_o, wr_data_o           cache array write port
//   busy_o, refill_done_o,
//   refill_err_o                  status
module icache_refill_ctrl #(
    parameter int N_WAY  = 4,
    parameter int WAY_W  = 2,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 128,
    parameter int OFF_W  = $clog2(LINE_W / 8),
    parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              miss_i,
    input  logic [ADDR_W-1:0] miss_paddr_i,
    input  logic [N_WAY-1:0]  valid_bits_i,
    input  logic [WAY_W-1:0]  lfsr_way_i,
    output logic              lfsr_en_o,
    output logic              l2_req_valid_o,
    input  logic              l2_req_ready_i,
    output logic [ADDR_W-1:0] l2_req_addr_o,
    input  logic              l2_resp_valid_i,
    input  logic [LINE_W-1:0] l2_resp_data_i,
    input  logic              l2_resp_err_i,
    input  logic              flush_i,
    output logic              wr_en_o,
    output logic [WAY_W-1:0]  wr_way_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [TAG_W-1:0]  wr_tag_o,
    output logic [LINE_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              refill_done_o,
    output logic              refill_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic              kill_q, kill_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [LINE_W-1:0] data_q, data_d;

    logic              set_full;
    logic [WAY_W-1:0]  victim_way;

    // Scan from the top down so the lowest invalid way is the last to win.
    always_comb begin
        set_full   = 1'b1;
        victim_way = lfsr_way_i;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!valid_bits_i[i]) begin
                set_full   = 1'b0;
                victim_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            way_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            data_q  <= data_d;
        end
    end

    // Pulses are suppressed while reset is asserted so a refill abandoned by
    // reset never produces a late strobe.
    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        tag_d          = tag_q;
        idx_d          = idx_q;
        way_d          = way_q;
        data_d         = data_q;
        lfsr_en_o      = 1'b0;
        l2_req_valid_o = 1'b0;
        wr_en_o        = 1'b0;
        refill_done_o  = 1'b0;
        refill_err_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (miss_i && !flush_i) begin
                        state_d   = S_REQ;
                        kill_d    = 1'b0;
                        tag_d     = miss_paddr_i[ADDR_W-1:OFF_W+IDX_W];
                        idx_d     = miss_paddr_i[OFF_W+IDX_W-1:OFF_W];
                        way_d     = victim_way;
                        lfsr_en_o = set_full;
                    end
                end
                S_REQ: begin
                    l2_req_valid_o = 1'b1;
                    if (l2_req_ready_i) begin
                        // Request already accepted: a same-cycle flush must
                        // kill the response rather than abandon the handshake.
                        state_d = S_WAIT;
                        kill_d  = flush_i;
                    end else if (flush_i) begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (l2_resp_valid_i) begin
                        state_d = S_IDLE;
                        kill_d  = 1'b0;
                        if (!kill_q && !flush_i) begin
                            if (l2_resp_err_i) begin
                                refill_err_o = 1'b1;
                            end else begin
                                data_d  = l2_resp_data_i;
                                state_d = S_WRITE;
                            end
                        end
                    end else if (flush_i) begin
                        kill_d = 1'b1;
                    end
                end
                S_WRITE: begin
                    wr_en_o       = 1'b1;
                    refill_done_o = 1'b1;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign l2_req_addr_o = {tag_q, idx_q, OFF_W'(0)};
    assign wr_way_o      = way_q;
    assign wr_idx_o      = idx_q;
    assign wr_tag_o      = tag_q;
    assign wr_data_o     = data_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         miss_i;
    logic [31:0]  miss_paddr_i;
    logic [3:0]   valid_bits_i;
    logic [1:0]   lfsr_way_i;
    logic         lfsr_en_o;
    logic         l2_req_valid_o;
    logic         l2_req_ready_i;
    logic [31:0]  l2_req_addr_o;
    logic         l2_resp_valid_i;
    logic [127:0] l2_resp_data_i;
    logic         l2_resp_err_i;
    logic         flush_i;
    logic         wr_en_o;
    logic [1:0]   wr_way_o;
    logic [5:0]   wr_idx_o;
    logic [21:0]  wr_tag_o;
    logic [127:0] wr_data_o;
    logic         busy_o;
    logic         refill_done_o;
    logic         refill_err_o;

    icache_refill_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .miss_i          (miss_i),
        .miss_paddr_i    (miss_paddr_i),
        .valid_bits_i    (valid_bits_i),
        .lfsr_way_i      (lfsr_way_i),
        .lfsr_en_o       (lfsr_en_o),
        .l2_req_valid_o  (l2_req_valid_o),
        .l2_req_ready_i  (l2_req_ready_i),
        .l2_req_addr_o   (l2_req_addr_o),
        .l2_resp_valid_i (l2_resp_valid_i),
        .l2_resp_data_i  (l2_resp_data_i),
        .l2_resp_err_i   (l2_resp_err_i),
        .flush_i         (flush_i),
        .wr_en_o         (wr_en_o),
        .wr_way_o        (wr_way_o),
        .wr_idx_o        (wr_idx_o),
        .wr_tag_o        (wr_tag_o),
        .wr_data_o       (wr_data_o),
        .busy_o          (busy_o),
        .refill_done_o   (refill_done_o),
        .refill_err_o    (refill_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           is_err;
        logic [1:0]   way;
        logic [5:0]   idx;
        logic [21:0]  tag;
        logic [127:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_lfsr = 0;
    int          obs_lfsr = 0;

    // modes: 0 normal, 1 flush in REQ, 2 flush in WAIT, 3 flush with response, 4 reset in WAIT
    localparam int M_NORMAL = 0, M_FLUSH_REQ = 1, M_FLUSH_WAIT = 2, M_FLUSH_RESP = 3, M_RESET = 4;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a result.
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_flush = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_addr  = '0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (lfsr_en_o) obs_lfsr++;
            if (wr_en_o || refill_done_o)
                check("done_with_wr", 128'(refill_done_o), 128'(wr_en_o));
            if (wr_en_o || refill_err_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 128'({wr_en_o, refill_err_o}), 128'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_kind", 128'({wr_en_o, refill_err_o}), e.is_err ? 128'(2'b01) : 128'(2'b10));
                    if (!e.is_err) begin
                        check("wr_way", 128'(wr_way_o), 128'(e.way));
                        check("wr_idx", 128'(wr_idx_o), 128'(e.idx));
                        check("wr_tag", 128'(wr_tag_o), 128'(e.tag));
                        check("wr_data", wr_data_o, e.data);
                    end
                end
            end
            if (l2_req_valid_o && l2_req_ready_i) begin
                if (req_q.size() == 0)
                    check("unexpected_req", 128'(l2_req_addr_o), 128'(0));
                else
                    check("req_addr", 128'(l2_req_addr_o), 128'(req_q.pop_front()));
            end
            if (!prev_rst && prev_valid && !prev_ready && !prev_flush) begin
                check("req_valid_hold", 128'(l2_req_valid_o), 128'(1));
                check("req_addr_hold", 128'(l2_req_addr_o), 128'(prev_addr));
            end
        end
        prev_valid = l2_req_valid_o;
        prev_ready = l2_req_ready_i;
        prev_flush = flush_i;
        prev_rst   = rst_i;
        prev_addr  = l2_req_addr_o;
    end

    task automatic do_miss(input logic [31:0] pa, input logic [3:0] vb, input logic [1:0] lw,
                           input int mode, input int rd, input int wd, input bit err,
                           input logic [127:0] dat);
        int         guard;
        bit         full;
        bit         found;
        logic [1:0] vict;
        exp_t       e;
        guard = 0;
        while (busy_o && guard < 50) begin
            step();
            guard++;
        end
        check("idle_before_miss", 128'(busy_o), 128'(0));
        full  = (vb == 4'hF);
        found = 1'b0;
        vict  = lw;
        for (int i = 0; i < 4; i++) begin
            if (!found && !vb[i]) begin
                vict  = 2'(i);
                found = 1'b1;
            end
        end
        e.is_err = err;
        e.way    = vict;
        e.idx    = 6'((pa >> 4) & 32'h3F);
        e.tag    = 22'(pa >> 10);
        e.data   = dat;

        miss_i       = 1'b1;
        miss_paddr_i = pa;
        valid_bits_i = vb;
        lfsr_way_i   = lw;
        #1;
        check("lfsr_en_accept", 128'(lfsr_en_o), 128'(full));
        if (full) exp_lfsr++;
        if (mode != M_FLUSH_REQ) req_q.push_back(pa & 32'hFFFF_FFF0);
        step();
        miss_i       = 1'b0;
        miss_paddr_i = $urandom;
        valid_bits_i = 4'($urandom);
        lfsr_way_i   = 2'($urandom);
        check("req_valid_lat", 128'(l2_req_valid_o), 128'(1));
        repeat (rd) step();
        if (mode == M_FLUSH_REQ) begin
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            check("flush_req_valid", 128'(l2_req_valid_o), 128'(0));
            check("flush_req_busy", 128'(busy_o), 128'(0));
            return;
        end
        l2_req_ready_i = 1'b1;
        step();
        l2_req_ready_i = 1'b0;
        if (mode == M_FLUSH_WAIT) begin
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
        end
        repeat (wd) step();
        if (mode == M_RESET) begin
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
            check("rst_flags", 128'({busy_o, l2_req_valid_o, wr_en_o, refill_done_o, refill_err_o, lfsr_en_o}), 128'(0));
            check("rst_regs", 128'({l2_req_addr_o, wr_way_o, wr_idx_o, wr_tag_o}), 128'(0));
            check("rst_data", wr_data_o, 128'(0));
            l2_resp_valid_i = 1'b1;
            l2_resp_data_i  = dat;
            step();
            l2_resp_valid_i = 1'b0;
            check("stray_resp_no_wr", 128'({wr_en_o, busy_o}), 128'(0));
            return;
        end
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = dat;
        l2_resp_err_i   = err;
        if (mode == M_FLUSH_RESP) flush_i = 1'b1;
        if (mode == M_NORMAL) exp_q.push_back(e);
        step();
        l2_resp_valid_i = 1'b0;
        l2_resp_err_i   = 1'b0;
        flush_i         = 1'b0;
        check("wr_latency", 128'(wr_en_o), 128'(mode == M_NORMAL && !err));
        if (mode == M_NORMAL && !err) begin
            flush_i = 1'($urandom_range(0, 1));
            step();
            flush_i = 1'b0;
        end
        check("back_to_idle", 128'(busy_o), 128'(0));
    endtask

    initial begin
        rst_i           = 1'b1;
        miss_i          = 1'b0;
        miss_paddr_i    = '0;
        valid_bits_i    = '0;
        lfsr_way_i      = '0;
        l2_req_ready_i  = 1'b0;
        l2_resp_valid_i = 1'b0;
        l2_resp_data_i  = '0;
        l2_resp_err_i   = 1'b0;
        flush_i         = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("idle_flags", 128'({busy_o, l2_req_valid_o, wr_en_o, refill_done_o, refill_err_o, lfsr_en_o}), 128'(0));
            step();
        end
        check("idle_addr", 128'({l2_req_addr_o, wr_way_o, wr_idx_o, wr_tag_o}), 128'(0));
        check("idle_data", wr_data_o, 128'(0));

        do_miss(32'h0001_2340, 4'b1011, 2'd0, M_NORMAL, 0, 3, 1'b0, {16{8'hA5}});
        do_miss(32'hDEAD_BEE0, 4'b1111, 2'd3, M_NORMAL, 1, 2, 1'b0, {4{32'h1234_5678}});
        do_miss(32'h0000_4560, 4'b0000, 2'd1, M_FLUSH_REQ, 3, 0, 1'b0, '0);
        do_miss(32'h00AB_CDE0, 4'b0111, 2'd0, M_FLUSH_WAIT, 0, 4, 1'b0, {16{8'h3C}});
        do_miss(32'h00AB_CDE0, 4'b0111, 2'd0, M_NORMAL, 0, 1, 1'b0, {16{8'hC3}});
        do_miss(32'h7000_0010, 4'b1101, 2'd2, M_NORMAL, 2, 2, 1'b1, {16{8'h77}});
        do_miss(32'h1357_9BD0, 4'b1111, 2'd1, M_RESET, 0, 2, 1'b0, {16{8'h99}});

        for (int t = 0; t < 40; t++) begin
            logic [3:0] vb;
            vb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            do_miss($urandom, vb, 2'($urandom), $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 4)) : M_NORMAL,
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3) == 0,
                    {$urandom, $urandom, $urandom, $urandom});
        end

        repeat (3) step();
        check("results_drained", 128'(exp_q.size()), 128'(0));
        check("reqs_drained", 128'(req_q.size()), 128'(0));
        check("lfsr_pulse_count", 128'(obs_lfsr), 128'(exp_lfsr));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
